// File: rtl/moore_seqgen.sv
// Moore serial pattern generator: sends a latched PAT_W-bit pattern MSB-first, reps times,
// with GAP idle bits between repetitions. Define MOORE_SEQGEN_PARITY_EN to append an even-parity bit per repetition.
module moore_seqgen #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  output logic             t,
  output logic             busy,
  output logic             last_bit,
  output logic             done
);

  localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(PAT_W - 1);
  localparam logic [BW-1:0] BIT_PEN  = BW'(PAT_W - 2);
  localparam logic [3:0]    GAP_LAST = 4'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_GAP, S_DONE
`ifdef MOORE_SEQGEN_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t           state;
  logic [PAT_W-1:0] sh;
  logic [PAT_W-1:0] pat_lat;
  logic [CNT_W-1:0] rep_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [3:0]       gap_cnt;
  logic             rep_end;

  // rep_end marks the cycle carrying the last bit of a repetition (data or parity)
`ifdef MOORE_SEQGEN_PARITY_EN
  assign rep_end = (state == S_PARITY);
`else
  assign rep_end = (state == S_SHIFT) && (bit_cnt == BIT_LAST);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      t        <= 1'b0;
      busy     <= 1'b0;
      last_bit <= 1'b0;
      done     <= 1'b0;
      rep_cnt  <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
    end else begin
      last_bit <= 1'b0;
      done     <= 1'b0;
      if (rep_end) begin
        rep_cnt <= rep_cnt - CNT_W'(1);
        if (rep_cnt != CNT_W'(1)) begin
          if (GAP > 0) begin
            state   <= S_GAP;
            t       <= 1'b0;
            gap_cnt <= '0;
          end else begin
            state   <= S_SHIFT;
            t       <= pat_lat[PAT_W-1];
            sh      <= pat_lat << 1;
            bit_cnt <= '0;
          end
        end else begin
          state <= S_DONE;
          t     <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              pat_lat <= pattern;
              rep_cnt <= reps;
              if (reps != '0) begin
                state   <= S_SHIFT;
                t       <= pattern[PAT_W-1];
                sh      <= pattern << 1;
                bit_cnt <= '0;
                busy    <= 1'b1;
              end else begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end
          end
          S_SHIFT: begin
`ifdef MOORE_SEQGEN_PARITY_EN
            if (bit_cnt == BIT_LAST) begin
              state    <= S_PARITY;
              t        <= ^pat_lat;
              last_bit <= (rep_cnt == CNT_W'(1));
            end else
`endif
            begin
              t       <= sh[PAT_W-1];
              sh      <= sh << 1;
              bit_cnt <= bit_cnt + BW'(1);
`ifndef MOORE_SEQGEN_PARITY_EN
              last_bit <= (bit_cnt == BIT_PEN) && (rep_cnt == CNT_W'(1));
`endif
            end
          end
          S_GAP: begin
            if (gap_cnt == GAP_LAST) begin
              state   <= S_SHIFT;
              t       <= pat_lat[PAT_W-1];
              sh      <= pat_lat << 1;
              bit_cnt <= '0;
            end else begin
              gap_cnt <= gap_cnt + 4'd1;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
